// File: rtl/dmem_ctrl.sv
// RV32 data memory controller: valid/ready request/response, byte-addressed sub-word
// access, programmable wait states. Define DMEM_MISALIGN_ERR_EN to flag misaligned accesses.
module dmem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              we_r;
  logic [2:0]        f3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       mem_r [DEPTH];

  logic              req_ready_r, rsp_valid_r, rsp_err_r, busy_r;
  logic [31:0]       rsp_rdata_r;

  logic              enter_resp_s;
  logic              eff_we_s;
  logic [2:0]        eff_f3_s;
  logic [ADDR_W-1:0] eff_addr_s, al_addr_s;
  logic [31:0]       eff_wdata_s;
  logic              illegal_s, oor_s, err_s, wr_en_s;
  logic [IDX_W-1:0]  idx_s;
  logic [1:0]        lane_s;
  logic [31:0]       rd_word_s, rdata_s, wr_word_s;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return w;
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] mask;
    case (f3)
      3'b000:  mask = 32'h0000_00FF << {lane, 3'b000};
      3'b001:  mask = 32'h0000_FFFF << {lane, 3'b000};
      3'b010:  mask = 32'hFFFF_FFFF;
      default: mask = 32'h0000_0000;
    endcase
    return (w & ~mask) | ((wd << {lane, 3'b000}) & mask);
  endfunction

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = WAIT_INIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Access decode; with zero wait states the access runs on the accept edge itself.
  always_comb begin
    enter_resp_s = (state_nxt_s == RESP) && (state_r != RESP);
    if (state_r == IDLE) begin
      eff_we_s    = req_we;
      eff_f3_s    = req_funct3;
      eff_addr_s  = req_addr;
      eff_wdata_s = req_wdata;
    end else begin
      eff_we_s    = we_r;
      eff_f3_s    = f3_r;
      eff_addr_s  = addr_r;
      eff_wdata_s = wdata_r;
    end
    case (eff_f3_s)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = eff_we_s;
      default:                illegal_s = 1'b1;
    endcase
    oor_s = (eff_addr_s >> (IDX_W + 2)) != '0;
`ifdef DMEM_MISALIGN_ERR_EN
    al_addr_s = eff_addr_s;
    err_s = illegal_s || oor_s ||
            ((eff_f3_s[1:0] == 2'b01) && eff_addr_s[0]) ||
            ((eff_f3_s == 3'b010) && (eff_addr_s[1:0] != 2'b00));
`else
    al_addr_s = eff_addr_s;
    if (eff_f3_s == 3'b010) begin
      al_addr_s[1:0] = 2'b00;
    end else if (eff_f3_s[1:0] == 2'b01) begin
      al_addr_s[0] = 1'b0;
    end else begin
      al_addr_s = eff_addr_s;
    end
    err_s = illegal_s || oor_s;
`endif
    idx_s     = al_addr_s[IDX_W+1:2];
    lane_s    = al_addr_s[1:0];
    rd_word_s = mem_r[idx_s];
    if (err_s || eff_we_s) begin
      rdata_s = 32'h0;
    end else begin
      rdata_s = load_ext(rd_word_s, eff_f3_s, lane_s);
    end
    wr_word_s = store_merge(rd_word_s, eff_wdata_s, eff_f3_s, lane_s);
    wr_en_s   = enter_resp_s && eff_we_s && !err_s;
  end

  // State, counter and captured request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      addr_r  <= '0;
      wdata_r <= 32'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if ((state_r == IDLE) && req_valid) begin
        we_r    <= req_we;
        f3_r    <= req_funct3;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

  // Storage, cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else if (wr_en_s) begin
      mem_r[idx_s] <= wr_word_s;
    end
  end

  // Registered outputs; response data is held for the whole RESP state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      rsp_rdata_r <= 32'h0;
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
      busy_r      <= (state_nxt_s != IDLE);
      if (enter_resp_s) begin
        rsp_rdata_r <= rdata_s;
        rsp_err_r   <= err_s;
      end else if (state_nxt_s != RESP) begin
        rsp_rdata_r <= 32'h0;
        rsp_err_r   <= 1'b0;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign busy      = busy_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
